regfile_param: RTL

- Next-generation register file for the MIPS datapath.
- Generalises the fixed 32x32, two-read/one-write file with:
  - parametrised data width and address width;
  - an optional hardwired zero register;
  - an optional registered read stage;
  - write-to-read forwarding;
  - a sequential clear engine that sweeps the array one entry per cycle.
- Sits between decode (read addresses) and writeback (write port). The clear engine serves context reset and test.

---
 rtl/regfile_param.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised two-read/one-write register file with forwarding and clear sweep
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int READ_LAT = 0,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Adr1,
    input  logic [ADDR_W-1:0] Adr2,
    input  logic [ADDR_W-1:0] Awr,
    input  logic [DATA_W-1:0] Din,
    input  logic              WrEn,
    input  logic              Clr,
    output logic [DATA_W-1:0] Dout1,
    output logic [DATA_W-1:0] Dout2,
    output logic              Busy,
    output logic              Done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_START = ADDR_W'((ZERO_REG != 0) ? 1 : 0);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];
    logic               wr_eff;
    logic [DATA_W-1:0]  dout1_d, dout2_d;

    // Writes only land while idle; entry 0 stays zero when hardwired.
    always_comb begin
        wr_eff = WrEn && (state_q == IDLE) && !((ZERO_REG != 0) && (Awr == '0));
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                if (wr_eff) begin
                    mem_d[Awr] = Din;
                end
                if (Clr) begin
                    state_d = CLEAR;
                    ptr_d   = PTR_START;
                end
            end
            CLEAR: begin
                mem_d[ptr_q] = '0;
                ptr_d        = ptr_q + ADDR_W'(1);
                if (ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Status flags are decoded from the next state so they align with the registered state.
        busy_d = (state_d == CLEAR);
        done_d = (state_d == CLEAR) && (ptr_d == PTR_LAST);
    end

    always_comb begin
        dout1_d = mem_q[Adr1];
        dout2_d = mem_q[Adr2];
        if ((BYPASS != 0) && wr_eff && (Awr == Adr1)) begin
            dout1_d = Din;
        end
        if ((BYPASS != 0) && wr_eff && (Awr == Adr2)) begin
            dout2_d = Din;
        end
        if ((ZERO_REG != 0) && (Adr1 == '0)) begin
            dout1_d = '0;
        end
        if ((ZERO_REG != 0) && (Adr2 == '0)) begin
            dout2_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mem_q   <= mem_d;
        end
    end

    generate
        if (READ_LAT != 0) begin : g_read_reg
            logic [DATA_W-1:0] dout1_q, dout2_q;
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    dout1_q <= '0;
                    dout2_q <= '0;
                end else begin
                    dout1_q <= dout1_d;
                    dout2_q <= dout2_d;
                end
            end
            assign Dout1 = dout1_q;
            assign Dout2 = dout2_q;
        end else begin : g_read_comb
            assign Dout1 = dout1_d;
            assign Dout2 = dout2_d;
        end
    endgenerate

    assign Busy = busy_q;
    assign Done = done_q;

endmodule
